interval_timer: RTL and testbench

Programmable interval timer that produces the `alert` interrupt consumed by the CPU. It sits directly upstream of the CPU and is configured through the memory controller's timer access path: the memory controller decodes CPU stores to timer addresses into write strobes, and CPU interrupt acknowledges into `timer_clr`. It supports one-shot and periodic modes, a programmable prescaler, and live count readback.

---
 rtl/timer_pkg.sv | 18 +
 rtl/timer_prescaler.sv | 44 ++++
 rtl/interval_timer.sv | 144 ++++++++++++++
 tb/tb_interval_timer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] SEL_PERIOD   = 2'd0;
  localparam logic [1:0] SEL_CTRL     = 2'd1;
  localparam logic [1:0] SEL_PRESCALE = 2'd2;

  localparam int EN       = 0;
  localparam int PERIODIC = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock: one-cycle tick every (prescale+1) enabled cycles.
// Latency: first tick prescale+1 edges after restart/enable edge.
// Backpressure: none; restart clears the count and suppresses that cycle's tick.
module timer_prescaler #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [PRE_W-1:0] prescale,
  input  logic             restart,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q, cnt_d;
  logic             at_end;

  // A lowered prescale can leave the count above the limit only for one
  // cycle (restart clears it), so >= keeps the wrap robust anyway.
  assign at_end = (cnt_q >= prescale);
  assign tick   = enable && !restart && at_end;

  // Next count: clear on restart or while idle, wrap at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || !enable) begin
      cnt_d = '0;
    end else if (at_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRE_W'(1);
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Programmable one-shot/periodic interval timer with sticky alert interrupt.
// Latency: writes act at their edge; alert rises period*(prescale+1) edges after start.
// Backpressure: none; every write strobe is accepted in the cycle it is high.
module interval_timer
  import timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_wr,
  input  logic [1:0]       timer_sel,
  input  logic [31:0]      timer_data,
  input  logic             timer_clr,
  output logic             alert,
  output logic [CNT_W-1:0] count,
  output logic             running
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             alert_q, alert_d;

  logic ctrl_wr, period_wr, prescale_wr;
  logic start;
  logic tick;

  assign ctrl_wr     = timer_wr && (timer_sel == SEL_CTRL);
  assign period_wr   = timer_wr && (timer_sel == SEL_PERIOD);
  assign prescale_wr = timer_wr && (timer_sel == SEL_PRESCALE);

  // Prescaler runs only in RUN; a start/restart or a new prescale value
  // begins a fresh tick interval.
  timer_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (state_q == RUN),
    .prescale (prescale_q),
    .restart  (start || prescale_wr),
    .tick     (tick)
  );

  // Register file, FSM next state, down-counter and alert flag.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    ctrl_d     = ctrl_q;
    count_d    = count_q;
    alert_d    = alert_q;
    start      = 1'b0;

    if (period_wr) begin
      period_d = timer_data[CNT_W-1:0];
    end
    if (prescale_wr) begin
      prescale_d = timer_data[PRE_W-1:0];
    end

    // Clear first so an expiry in the same cycle overrides it.
    if (timer_clr) begin
      alert_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ctrl_wr) begin
          ctrl_d[PERIODIC] = timer_data[PERIODIC];
          if (timer_data[EN] && (period_q != '0)) begin
            state_d    = RUN;
            count_d    = period_q;
            ctrl_d[EN] = 1'b1;
            start      = 1'b1;
          end else begin
            // Enabling with a zero period is refused; en reads back 0.
            ctrl_d[EN] = 1'b0;
          end
        end
      end

      RUN: begin
        if (ctrl_wr) begin
          ctrl_d[PERIODIC] = timer_data[PERIODIC];
          if (timer_data[EN] && (period_q != '0)) begin
            count_d    = period_q;
            ctrl_d[EN] = 1'b1;
            start      = 1'b1;
          end else begin
            // Stop: count freezes where it is.
            state_d    = IDLE;
            ctrl_d[EN] = 1'b0;
          end
        end else if (tick && ctrl_q[EN]) begin
          if (count_q > CNT_W'(1)) begin
            count_d = count_q - CNT_W'(1);
          end else begin
            alert_d = 1'b1;
            if (ctrl_q[PERIODIC] && (period_q != '0)) begin
              count_d = period_q;
            end else begin
              count_d    = '0;
              state_d    = IDLE;
              ctrl_d[EN] = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset is asynchronous so a mid-run reset is immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      period_q   <= '0;
      prescale_q <= '0;
      ctrl_q     <= '0;
      count_q    <= '0;
      alert_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      ctrl_q     <= ctrl_d;
      count_q    <= count_d;
      alert_q    <= alert_d;
    end
  end

  assign alert   = alert_q;
  assign count   = count_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_interval_timer.sv
module tb_interval_timer;

  logic        clk;
  logic        rst_n;
  logic        timer_wr;
  logic [1:0]  timer_sel;
  logic [31:0] timer_data;
  logic        timer_clr;
  logic        alert;
  logic [31:0] count;
  logic        running;

  int n_checks = 0;
  int n_fail   = 0;

  interval_timer #(
    .CNT_W (32),
    .PRE_W (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .timer_wr   (timer_wr),
    .timer_sel  (timer_sel),
    .timer_data (timer_data),
    .timer_clr  (timer_clr),
    .alert      (alert),
    .count      (count),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic wr(input logic [1:0] sel, input logic [31:0] dat);
    timer_wr   = 1'b1;
    timer_sel  = sel;
    timer_data = dat;
    @(negedge clk);
    timer_wr   = 1'b0;
    timer_sel  = 2'd0;
    timer_data = 32'd0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_pulse();
    timer_clr = 1'b1;
    @(negedge clk);
    timer_clr = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    timer_wr   = 1'b0;
    timer_sel  = 2'd0;
    timer_data = 32'd0;
    timer_clr  = 1'b0;

    // Reset
    step(3);
    check("rst_alert", {31'd0, alert}, 32'd0);
    check("rst_count", count, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    rst_n = 1'b1;
    step(1);
    wr(2'd3, 32'd5);           // reserved: must not load period
    wr(2'd1, 32'd1);
    check("en_zero_period_running", {31'd0, running}, 32'd0);
    check("en_zero_period_count", count, 32'd0);

    // One-shot, period 5, prescale 0
    wr(2'd0, 32'd5);
    wr(2'd2, 32'd0);
    wr(2'd1, 32'd1);           // E0
    check("os_start_running", {31'd0, running}, 32'd1);
    check("os_start_count", count, 32'd5);
    step(4);                   // E4
    check("os_e4_count", count, 32'd1);
    check("os_e4_alert", {31'd0, alert}, 32'd0);
    step(1);                   // E5
    check("os_e5_alert", {31'd0, alert}, 32'd1);
    check("os_e5_running", {31'd0, running}, 32'd0);
    check("os_e5_count", count, 32'd0);
    step(3);
    check("os_sticky", {31'd0, alert}, 32'd1);
    clr_pulse();
    check("os_cleared", {31'd0, alert}, 32'd0);

    // Periodic, period 3, prescale 1
    wr(2'd0, 32'd3);
    wr(2'd2, 32'd1);
    wr(2'd1, 32'd3);           // E0
    check("per_start_count", count, 32'd3);
    step(2);                   // E2
    check("per_e2_count", count, 32'd2);
    step(3);                   // E5
    check("per_e5_count", count, 32'd1);
    check("per_e5_alert", {31'd0, alert}, 32'd0);
    step(1);                   // E6
    check("per_e6_alert", {31'd0, alert}, 32'd1);
    check("per_e6_count", count, 32'd3);
    check("per_e6_running", {31'd0, running}, 32'd1);
    clr_pulse();               // E7
    check("per_e7_alert", {31'd0, alert}, 32'd0);
    check("per_e7_count", count, 32'd3);
    step(1);                   // E8
    check("per_e8_count", count, 32'd2);
    step(3);                   // E11
    check("per_e11_alert", {31'd0, alert}, 32'd0);
    check("per_e11_count", count, 32'd1);
    step(1);                   // E12
    check("per_e12_alert", {31'd0, alert}, 32'd1);
    check("per_e12_count", count, 32'd3);
    wr(2'd1, 32'd0);           // stop with alert pending
    check("stop_keeps_alert", {31'd0, alert}, 32'd1);
    check("stop_running", {31'd0, running}, 32'd0);
    check("stop_count", count, 32'd3);
    clr_pulse();

    // Simultaneous set and clear, period 2
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd2);
    wr(2'd1, 32'd3);           // E0
    step(1);                   // E1
    check("sim_e1_count", count, 32'd1);
    clr_pulse();               // E2: expiry with clear
    check("sim_set_wins", {31'd0, alert}, 32'd1);
    check("sim_e2_count", count, 32'd2);
    clr_pulse();               // E3
    check("sim_e3_alert", {31'd0, alert}, 32'd0);
    check("sim_e3_count", count, 32'd1);
    wr(2'd1, 32'd0);

    // Live reconfiguration, period 4 then 8
    wr(2'd0, 32'd4);
    wr(2'd1, 32'd3);           // E0
    step(2);                   // E2
    check("live_e2_count", count, 32'd2);
    wr(2'd0, 32'd8);           // E3
    check("live_e3_count", count, 32'd1);
    check("live_e3_alert", {31'd0, alert}, 32'd0);
    step(1);                   // E4
    check("live_e4_alert", {31'd0, alert}, 32'd1);
    check("live_e4_reload", count, 32'd8);
    clr_pulse();               // E5
    check("live_e5_count", count, 32'd7);
    step(6);                   // E11
    check("live_e11_count", count, 32'd1);
    check("live_e11_alert", {31'd0, alert}, 32'd0);
    step(1);                   // E12
    check("live_e12_alert", {31'd0, alert}, 32'd1);
    check("live_e12_count", count, 32'd8);
    step(2);                   // E14
    check("live_e14_count", count, 32'd6);
    wr(2'd1, 32'd0);           // E15
    check("freeze_count", count, 32'd6);
    check("freeze_running", {31'd0, running}, 32'd0);
    step(3);
    check("freeze_hold", count, 32'd6);

    // Async reset mid-run (alert still pending from above)
    wr(2'd0, 32'd10);
    wr(2'd1, 32'd1);           // E0
    step(3);                   // E3
    check("ar_pre_count", count, 32'd7);
    check("ar_pre_alert", {31'd0, alert}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_count", count, 32'd0);
    check("ar_alert", {31'd0, alert}, 32'd0);
    check("ar_running", {31'd0, running}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(4);
    check("ar_no_resume_running", {31'd0, running}, 32'd0);
    check("ar_no_resume_count", count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
